// File: rtl/ul_tdl_agc_ctrl_60m.sv
// Closed-loop UL TDL 60M AGC: per-antenna windowed I^2+Q^2 power steers each DDC gain index toward a lo/hi band.
// Optional power report port pair is built when UL_TDL_AGC_PWR_RPT_EN is defined.
module ul_tdl_agc_ctrl_60m #(
  parameter int XNUM     = 8,
  parameter int WIN_LOG2 = 10,
  parameter int GAIN_MAX = 255,
  parameter int GAIN_RST = 0
) (
  input  logic                clk_245,
  input  logic                asy_rst_n,
  input  logic [31:0]         i_data,
  input  logic                i_data_valid,
  input  logic                i_fram_hd,
  input  logic                i_agc_en,
  input  logic [7:0]          i_gain_init,
  input  logic [3:0]          i_gain_step,
  input  logic [31:0]         i_pwr_hi,
  input  logic [31:0]         i_pwr_lo,
  output logic [XNUM*8-1:0]   o_ddc_gain_lte,
  output logic                o_gain_upd
`ifdef UL_TDL_AGC_PWR_RPT_EN
  ,
  input  logic [2:0]          i_rpt_sel,
  output logic [31:0]         o_pwr_rpt
`endif
);

  localparam int SW = $clog2(XNUM);
  localparam int AW = 32 + WIN_LOG2;
  localparam logic [SW-1:0]       SLOT_LAST  = SW'(XNUM - 1);
  localparam logic [WIN_LOG2-1:0] RND_LAST   = '1;
  localparam logic [7:0]          GAIN_MAX_V = 8'(GAIN_MAX);
  localparam logic [7:0]          GAIN_RST_V = 8'(GAIN_RST);

  typedef enum logic [1:0] {ST_IDLE, ST_UPD, ST_DONE} state_t;

  // Slot of the sample currently on i_data; a valid header pins it to slot 0.
  logic [SW-1:0] slot_cnt_reg;
  logic [SW-1:0] slot_cur;
  assign slot_cur = i_fram_hd ? '0 : slot_cnt_reg;

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      slot_cnt_reg <= '0;
    end else if (i_data_valid) begin
      slot_cnt_reg <= (slot_cur == SLOT_LAST) ? '0 : slot_cur + 1'b1;
    end
  end

  logic signed [15:0] d_i;
  logic signed [15:0] d_q;
  logic [30:0]        i_sq;
  logic [30:0]        q_sq;
  assign d_i  = i_data[31:16];
  assign d_q  = i_data[15:0];
  assign i_sq = 31'(d_i) * 31'(d_i);
  assign q_sq = 31'(d_q) * 31'(d_q);

  logic          s1_vld_reg, s1_hd_reg;
  logic [SW-1:0] s1_slot_reg;
  logic [30:0]   s1_isq_reg, s1_qsq_reg;
  logic          s2_vld_reg, s2_hd_reg;
  logic [SW-1:0] s2_slot_reg;
  logic [31:0]   s2_p_reg;

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      s1_vld_reg  <= 1'b0;
      s1_hd_reg   <= 1'b0;
      s1_slot_reg <= '0;
      s1_isq_reg  <= '0;
      s1_qsq_reg  <= '0;
      s2_vld_reg  <= 1'b0;
      s2_hd_reg   <= 1'b0;
      s2_slot_reg <= '0;
      s2_p_reg    <= '0;
    end else begin
      s1_vld_reg <= i_data_valid;
      s1_hd_reg  <= i_data_valid & i_fram_hd;
      if (i_data_valid) begin
        s1_slot_reg <= slot_cur;
        s1_isq_reg  <= i_sq;
        s1_qsq_reg  <= q_sq;
      end
      s2_vld_reg <= s1_vld_reg;
      s2_hd_reg  <= s1_hd_reg;
      if (s1_vld_reg) begin
        s2_slot_reg <= s1_slot_reg;
        s2_p_reg    <= 32'(s1_isq_reg) + 32'(s1_qsq_reg);
      end
    end
  end

  logic [WIN_LOG2-1:0] rnd_reg;
  logic                close_win;
  logic                hd_s3;
  assign close_win = s2_vld_reg && (s2_slot_reg == SLOT_LAST) && (rnd_reg == RND_LAST);
  assign hd_s3     = s2_vld_reg && s2_hd_reg;

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      rnd_reg <= '0;
    end else if (s2_vld_reg) begin
      if (close_win || hd_s3) begin
        rnd_reg <= '0;
      end else if (s2_slot_reg == SLOT_LAST) begin
        rnd_reg <= rnd_reg + 1'b1;
      end
    end
  end

  // Shadow keeps only the mean (sum >> WIN_LOG2), latched with the closing sample folded in.
  logic [AW-1:0] acc_reg    [XNUM];
  logic [31:0]   shadow_reg [XNUM];

  for (genvar gi = 0; gi < XNUM; gi++) begin : g_acc
    logic          sel;
    logic [AW-1:0] acc_add;
    assign sel     = (s2_slot_reg == SW'(gi));
    assign acc_add = acc_reg[gi] + (sel ? AW'(s2_p_reg) : '0);

    always_ff @(posedge clk_245 or negedge asy_rst_n) begin
      if (!asy_rst_n) begin
        acc_reg[gi]    <= '0;
        shadow_reg[gi] <= '0;
      end else if (s2_vld_reg) begin
        if (close_win) begin
          shadow_reg[gi] <= acc_add[AW-1:WIN_LOG2];
          acc_reg[gi]    <= '0;
        end else if (hd_s3) begin
          acc_reg[gi] <= sel ? AW'(s2_p_reg) : '0;
        end else begin
          acc_reg[gi] <= acc_add;
        end
      end
    end
  end

  state_t        state_reg;
  logic [SW-1:0] upd_idx_reg;
  logic          gain_upd_reg;
  logic [7:0]    gain_reg [XNUM];
  logic [31:0]   mean_cur;
  logic [7:0]    gain_cur;
  logic [7:0]    gain_next;
  logic [8:0]    gain_sum;

  assign mean_cur   = shadow_reg[upd_idx_reg];
  assign gain_cur   = gain_reg[upd_idx_reg];
  assign gain_sum   = {1'b0, gain_cur} + {5'b0, i_gain_step};
  assign o_gain_upd = gain_upd_reg;

  // Over-power test first so a misconfigured lo>hi band still backs the gain off.
  always_comb begin
    gain_next = gain_cur;
    if (mean_cur > i_pwr_hi) begin
      gain_next = (gain_cur < {4'b0, i_gain_step}) ? 8'd0 : gain_cur - {4'b0, i_gain_step};
    end else if (mean_cur < i_pwr_lo) begin
      gain_next = (gain_sum > {1'b0, GAIN_MAX_V}) ? GAIN_MAX_V : gain_sum[7:0];
    end
  end

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      state_reg    <= ST_IDLE;
      upd_idx_reg  <= '0;
      gain_upd_reg <= 1'b0;
    end else begin
      gain_upd_reg <= 1'b0;
      if (!i_agc_en) begin
        state_reg   <= ST_IDLE;
        upd_idx_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (close_win) begin
              state_reg   <= ST_UPD;
              upd_idx_reg <= '0;
            end
          end
          ST_UPD: begin
            if (upd_idx_reg == SLOT_LAST) begin
              state_reg <= ST_DONE;
            end else begin
              upd_idx_reg <= upd_idx_reg + 1'b1;
            end
          end
          ST_DONE: begin
            gain_upd_reg <= 1'b1;
            state_reg    <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < XNUM; gi++) begin : g_gain
    always_ff @(posedge clk_245 or negedge asy_rst_n) begin
      if (!asy_rst_n) begin
        gain_reg[gi] <= GAIN_RST_V;
      end else if (!i_agc_en) begin
        gain_reg[gi] <= i_gain_init;
      end else if ((state_reg == ST_UPD) && (upd_idx_reg == SW'(gi))) begin
        gain_reg[gi] <= gain_next;
      end
    end
    assign o_ddc_gain_lte[8*gi +: 8] = gain_reg[gi];
  end

`ifdef UL_TDL_AGC_PWR_RPT_EN
  logic [31:0] pwr_rpt_reg;
  assign o_pwr_rpt = pwr_rpt_reg;

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      pwr_rpt_reg <= '0;
    end else if (state_reg == ST_UPD) begin
      if ({1'b0, i_rpt_sel} >= 4'(XNUM)) begin
        pwr_rpt_reg <= '0;
      end else if (4'(upd_idx_reg) == {1'b0, i_rpt_sel}) begin
        pwr_rpt_reg <= mean_cur;
      end
    end
  end
`endif

endmodule
